stream_fifo_stage: RTL and testbench
====================================

Name: stream_fifo_stage

Overview:
- Small ready/valid FIFO buffer sitting directly downstream of a skid-controlled unit.
- Consumes the unit's out_valid/out_data stream and re-presents it to the next consumer.
- Decouples back-pressure so a stalled consumer does not immediately stall the producing unit, absorbing up to DEPTH words.
- in_ready does not combinationally depend on out_ready, which breaks the ready path between stages.

Parameters:
- DATA_W, 32, width of data word
- DEPTH, 4, number of storage entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- flush  input  1  synchronous clear of all stored words
- in_valid  input  1  upstream word valid
- in_ready  output  1  FIFO can accept a word this cycle
- in_data  input  DATA_W  upstream word
- out_valid  output  1  head word valid
- out_ready  input  1  downstream accepts head word
- out_data  output  DATA_W  head word
- level  output  AW+1  number of stored words, 0..DEPTH
- full  output  1  level == DEPTH
- empty  output  1  level == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - Pointers and level are 0; empty=1, full=0.
  - in_ready=1, out_valid=0.
  - out_data is don't-care; storage array is not reset.
- Transfer definitions:
  - push = in_valid && in_ready
  - pop = out_valid && out_ready
- Ready and valid:
  - in_ready = !full && !flush. It does not depend on out_ready, so no push is accepted when full, even if a pop occurs in the same cycle.
  - out_valid = !empty && !flush. out_data = mem[rd_ptr], read asynchronously from storage.
- Push and pop:
  - Latency: a word pushed in cycle N is visible at out_valid/out_data in cycle N+1 at the earliest.
  - push only: mem[wr_ptr] <= in_data; wr_ptr increments; level+1.
  - pop only: rd_ptr increments; level-1.
  - push and pop together (0 < level < DEPTH): both pointers advance; level unchanged; order preserved.
- Pointers: AW bits each; wrap from DEPTH-1 to 0 naturally (power-of-two depth). full and empty are derived from level, never from pointer compare.
- flush:
  - Sets rd_ptr=wr_ptr=0 and level=0 at the clock edge.
  - Has priority over push and pop, and forces in_ready=0 and out_valid=0 during that cycle, so no handshake completes.
- Boundaries:
  - At level==DEPTH-1, a push with no pop sets full next cycle.
  - At level==1, a pop with no push sets empty next cycle.
  - in_valid while full: word held upstream, FIFO state unchanged.
  - out_ready while empty: no effect.
- rst asserted mid-operation: all stored words are discarded immediately, and outputs return to reset values asynchronously.
- Protocol: upstream must hold in_valid/in_data stable until push. The FIFO holds out_valid/out_data stable until pop (except on flush or rst).

Optional Feature:
- Macro: STREAM_FIFO_BYPASS_EN.
- Defined:
  - When empty, out_valid = in_valid && !flush and out_data = in_data (combinational fall-through, zero latency).
  - If empty and in_valid && out_ready, the word passes straight through and is not stored; level stays 0.
  - If empty and in_valid && !out_ready, the word is stored normally.
  - in_ready remains !full && !flush.
- Undefined: minimum latency of 1 cycle, as in Behaviour; no combinational path from in_* to out_*.

Test Plan:
- Reset with rst asserted for 3 cycles, then released -> in_ready=1, out_valid=0, level=0, empty=1, full=0.
- Fill, DEPTH=4: out_ready=0; push 0x11,0x22,0x33,0x44 -> level=4, full=1, in_ready=0. A fifth word 0x55 held with in_valid=1 is not accepted. Then out_ready=1 -> pops 0x11,0x22,0x33,0x44 in order, then 0x55 enters.
- Concurrent push/pop at level=2: push 0xA0 while popping for 4 cycles -> level stays 2 each cycle, output order preserved.
- Wrap-around with random stalls: stream 0..19 with out_ready toggling pseudo-randomly -> all 20 words out in order, no loss or duplication, level never > 4.
- Flush: at level=3 with in_valid=1 and in_data=0x77, assert flush for 1 cycle -> in_ready=0, out_valid=0 that cycle; next cycle level=0, empty=1. 0x77 is not stored and is accepted afterwards.
- Bypass (with STREAM_FIFO_BYPASS_EN): empty, in_valid=1, in_data=0x5A, out_ready=1 -> same cycle out_valid=1, out_data=0x5A, level stays 0. Without the macro: out_valid=1 only in the next cycle.

Source files
------------

// File: rtl/stream_fifo_stage.sv
// stream_fifo_stage: small ready/valid FIFO that decouples downstream
// back-pressure from the producing unit, absorbing up to DEPTH words.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              synchronous clear of all stored words
//   in_valid/in_ready/in_data     upstream handshake and word
//   out_valid/out_ready/out_data  downstream handshake and head word
//   level              number of stored words, 0..DEPTH
//   full, empty        level == DEPTH, level == 0
//
// Optional build macro: STREAM_FIFO_BYPASS_EN
//   When defined, an empty FIFO presents in_valid/in_data combinationally on
//   the output, and a word taken downstream in the same cycle is never stored.
//   When undefined, the minimum latency is one cycle and no in_* -> out_* path
//   exists.
module stream_fifo_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;

    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // Status is derived from the level counter only, never from pointers.
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // in_ready ignores out_ready so the ready path is broken between stages.
    assign in_ready = !full && !flush;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

`ifdef STREAM_FIFO_BYPASS_EN
    logic bypass_pass;

    // Empty FIFO falls through: the upstream word is presented directly.
    assign out_valid   = !flush && (!empty || in_valid);
    assign out_data    = empty ? in_data : mem[rd_ptr_q];

    // A fall-through word consumed in the same cycle never touches storage.
    assign bypass_pass = empty && in_valid && out_ready && !flush;
    assign wr_en       = push && !bypass_pass;
    assign rd_en       = pop && !empty;
`else
    assign out_valid = !empty && !flush;
    assign out_data  = mem[rd_ptr_q];
    assign wr_en     = push;
    assign rd_en     = pop;
`endif

    // Next-state for pointers and level; flush overrides any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are not reset. flush blocks writes via in_ready.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo_stage.sv
// Self-checking bench for stream_fifo_stage: directed scenarios plus
// randomized traffic, checked against a queue-based reference model.
module tb_stream_fifo_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AW     = $clog2(DEPTH);

`ifdef STREAM_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [AW:0]       level;
    logic              full;
    logic              empty;

    int tests_run;
    int tests_failed;

    logic [DATA_W-1:0] model_q[$];
    int                popped_cnt;

    stream_fifo_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs were set after the falling edge; compare all
    // outputs against the model mid-cycle, then advance the model at posedge.
    task automatic step(output bit pushed);
        bit               e_in_ready;
        bit               e_out_valid;
        logic [DATA_W-1:0] e_data;
        bit               do_push;
        bit               do_pop;
        bit               passes;
        int               n;
        #1;
        n           = model_q.size();
        e_in_ready  = (n < DEPTH) && !flush;
        e_out_valid = !flush && ((n > 0) || (BYP && in_valid));
        e_data      = (n > 0) ? model_q[0] : in_data;
        check("in_ready",  64'(in_ready),  64'(e_in_ready));
        check("out_valid", 64'(out_valid), 64'(e_out_valid));
        check("level",     64'(level),     64'(n));
        check("full",      64'(full),      64'(n == DEPTH));
        check("empty",     64'(empty),     64'(n == 0));
        if (e_out_valid) begin
            check("out_data", 64'(out_data), 64'(e_data));
        end
        do_push = in_valid && e_in_ready;
        do_pop  = e_out_valid && out_ready;
        passes  = BYP && (n == 0) && do_push && do_pop;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else if (!passes) begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
        if (do_pop) popped_cnt++;
        pushed = do_push;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    // Offer one word and hold it until accepted, bounded by a cycle budget.
    task automatic push_word(input logic [DATA_W-1:0] d, input int budget);
        bit p;
        int k;
        in_valid = 1'b1;
        in_data  = d;
        p = 1'b0;
        k = 0;
        while (!p && k < budget) begin
            step(p);
            k++;
        end
        check("push_accepted", 64'(p), 64'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        bit p;
        int cnt;
        int budget;
        logic [DATA_W-1:0] seq;

        tests_run    = 0;
        tests_failed = 0;
        popped_cnt   = 0;
        idle_inputs();

        // Reset held for 3 cycles.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_level",     64'(level),     64'(0));
        check("rst_empty",     64'(empty),     64'(1));
        check("rst_full",      64'(full),      64'(0));
        @(negedge clk);

        // Fill to DEPTH, hold a fifth word, then drain in order.
        out_ready = 1'b0;
        push_word(32'h11, 4);
        push_word(32'h22, 4);
        push_word(32'h33, 4);
        push_word(32'h44, 4);
        in_valid = 1'b1;
        in_data  = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step(p);
            check("full_hold_no_push", 64'(p), 64'(0));
        end
        check("fill_level", 64'(level), 64'(DEPTH));
        out_ready = 1'b1;
        step(p);
        check("full_pop_no_push", 64'(p), 64'(0));
        step(p);
        check("fifth_enters", 64'(p), 64'(1));
        in_valid = 1'b0;
        repeat (6) step(p);
        check("drained", 64'(level), 64'(0));

        // Concurrent push/pop at level 2.
        out_ready = 1'b0;
        push_word(32'h01, 4);
        push_word(32'h02, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(i);
            step(p);
            check("conc_level", 64'(level), 64'(2));
        end
        in_valid = 1'b0;
        repeat (3) step(p);

        // Bypass / first-word latency from empty.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h5A;
        #1;
        check("empty_in_out_valid", 64'(out_valid), 64'(BYP));
        step(p);
        in_valid = 1'b0;
        check("after_first_level", 64'(level), 64'(BYP ? 0 : 1));
        repeat (2) step(p);

        // Stream 0..19 with random stalls.
        popped_cnt = 0;
        seq = '0;
        budget = 0;
        in_valid = 1'b0;
        while ((seq < 20 || in_valid) && budget < 500) begin
            if (!in_valid && seq < 20 && ($urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = seq;
                seq++;
            end
            out_ready = 1'($urandom_range(0, 1));
            step(p);
            if (p) in_valid = 1'b0;
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (model_q.size() > 0 && budget < 20) begin
            step(p);
            budget++;
        end
        check("stream_count", 64'(popped_cnt), 64'(20));

        // Flush at level 3 with a pending word.
        out_ready = 1'b0;
        push_word(32'hC1, 4);
        push_word(32'hC2, 4);
        push_word(32'hC3, 4);
        in_valid = 1'b1;
        in_data  = 32'h77;
        flush    = 1'b1;
        step(p);
        check("flush_no_push", 64'(p), 64'(0));
        flush = 1'b0;
        #1;
        check("post_flush_level", 64'(level), 64'(0));
        check("post_flush_empty", 64'(empty), 64'(1));
        step(p);
        check("77_accepted", 64'(p), 64'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step(p);

        // Random traffic with occasional flush.
        cnt = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            step(p);
            if (p) begin
                in_valid = 1'b0;
                cnt++;
            end
        end
        flush = 1'b0;
        check("random_some_pushes", 64'(cnt > 50), 64'(1));

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        in_valid  = 1'b0;
        push_word(32'hD1, 4);
        push_word(32'hD2, 4);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check("async_rst_level",     64'(level),     64'(0));
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_empty",     64'(empty),     64'(1));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(p);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

endmodule
